// File: rtl/arb83_ctrl_if.sv
// Request/grant bundle between requesters and the arb83_ctrl arbiter.
// The master side drives requests and control; the slave (arbiter) side returns the grant.
interface arb83_ctrl_if;
    logic       ena;
    logic       mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output ena, mode, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  ena, mode, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/arb83_ctrl.sv
// Eight-requester arbiter with fixed or rotating priority.
// A grant is held until done, withdrawal, disable or hold timeout.
module arb83_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arb83_ctrl_if.slave   bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] owner, owner_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] gnt_q, gnt_nxt;
    logic [2:0] gnt_id_q, gnt_id_nxt;
    logic       gnt_valid_q, gnt_valid_nxt;
    logic       timeout_q, timeout_nxt;

    logic [7:0] req_rot;
    logic [2:0] fixed_w;
    logic [2:0] rr_w;
    logic [2:0] win;
    logic       owner_gone;
    logic       to_hit;
    logic       release_now;

    // Shared 8-to-3 priority encoder: index of the highest set bit, 0 if none.
    function automatic logic [2:0] pe8to3(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Rotate requests so that ptr lands on bit 7; the encoder then yields the
    // first requester in descending order starting at ptr.
    always_comb begin
        req_rot = '0;
        for (int k = 0; k < 8; k++) begin
            req_rot[k] = bus.req[3'(k) + ptr + 3'd1];
        end
    end

    assign fixed_w     = pe8to3(bus.req);
    assign rr_w        = pe8to3(req_rot) + ptr + 3'd1;
    assign win         = bus.mode ? rr_w : fixed_w;
    assign owner_gone  = !bus.req[owner];
    assign to_hit      = TO_EN && (cnt == TO_LAST);
    assign release_now = bus.done || owner_gone || !bus.ena || to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd7;
            owner       <= 3'd0;
            cnt         <= 8'd0;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            gnt_q       <= gnt_nxt;
            gnt_id_q    <= gnt_id_nxt;
            gnt_valid_q <= gnt_valid_nxt;
            timeout_q   <= timeout_nxt;
        end
    end

    // Timeout pulses only when the hold limit is the sole reason for release.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt_q;
        gnt_id_nxt    = gnt_id_q;
        gnt_valid_nxt = gnt_valid_q;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                gnt_nxt       = 8'd0;
                gnt_id_nxt    = 3'd0;
                gnt_valid_nxt = 1'b0;
                if (bus.ena && (bus.req != 8'd0)) begin
                    state_nxt     = GRANT;
                    owner_nxt     = win;
                    ptr_nxt       = win - 3'd1;
                    cnt_nxt       = 8'd0;
                    gnt_nxt       = 8'd1 << win;
                    gnt_id_nxt    = win;
                    gnt_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt     = IDLE;
                    gnt_nxt       = 8'd0;
                    gnt_id_nxt    = 3'd0;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = to_hit && !bus.done && !owner_gone && bus.ena;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: doc/arb83_ctrl.md
# arb83_ctrl

Sequential 8-requester arbiter built around the team's 8-to-3 priority-encoding function. It takes eight request lines and selects one winner, by fixed priority (highest index wins) or by rotating priority. It then holds that grant until the owner releases it or a timeout expires. It sits in front of a shared resource and drives its select, reporting the winner both one-hot and as a 3-bit index.

## Interface
- `TIMEOUT`, default 16: maximum cycles a grant may be held. 0 disables the timeout. Legal range 0–255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  arbiter enable. Low forces release and blocks new grants.
- `mode`  in  1  0 = fixed priority (7 highest … 0 lowest), 1 = round-robin.
- `req`  in  8  request lines, level-sensitive, one per requester.
- `done`  in  1  current owner finished; releases the grant.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_id`  out  3  index of the granted requester, registered. 0 when no grant.
- `gnt_valid`  out  1  a grant is active, registered.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, GRANT.
- Registers: `ptr[2:0]` (round-robin start), `owner[2:0]`, `cnt[7:0]` (hold counter).
- IDLE, when `ena`=1 and `req`≠0:
  - Select the winner `w`.
  - Load `gnt`=1<<`w`, `gnt_id`=`w`, `gnt_valid`=1, `cnt`=0.
  - Go to GRANT.
- IDLE, when `ena`=0 or `req`=0: stay in IDLE; all grant outputs are 0.
- Winner selection, `mode`=0: highest set bit of `req`.
- Winner selection, `mode`=1:
  - Search order is `ptr`, `ptr`-1, …, 0, 7, …, `ptr`+1 (mod 8).
  - The first set bit in that order wins.
  - On each grant, `ptr` ← `w`-1 mod 8 (grant to 0 wraps `ptr` to 7).
  - `ptr` is updated in both modes. A mode switch therefore continues the rotation from the last winner.
- `mode` is sampled only in IDLE. Changing it during GRANT has no effect on the current grant.
- GRANT, release conditions (any one, checked every cycle):
  - `done`=1,
  - `req[owner]`=0 (owner withdrew),
  - `ena`=0,
  - `TIMEOUT`≠0 and `cnt`=`TIMEOUT`-1.
- On release:
  - Clear `gnt`, `gnt_id`, `gnt_valid`.
  - Go to IDLE.
  - Pulse `timeout`=1 only when the timeout condition alone caused the release. If `done` or a withdrawal coincides with the timeout, no pulse.
- Otherwise in GRANT, `cnt` increments, saturating at 255.
- Requests from non-owners during GRANT are ignored; there is no preemption.
- `done` outside GRANT is ignored.

## Timing
- Reset (`rst_n`=0, asynchronous) gives:
  - state=IDLE, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0,
  - `ptr`=7, `owner`=0, `cnt`=0.
- Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Grant latency: `req` sampled high at edge t in IDLE gives `gnt` valid after edge t (visible in cycle t+1).
- Release latency: a release condition true at edge t clears `gnt` after edge t.
- Minimum gap between grants: one IDLE cycle. Back-to-back grants to different requesters are separated by exactly one cycle with `gnt_valid`=0.
- Hold time: with `TIMEOUT`=N and no other release, `gnt_valid` is high for exactly N cycles. `timeout` pulses in the first cycle after the grant drops.
- Outputs depend only on registers; no combinational path from `req` or `done` to any output.
- `gnt` is always either 0 or one-hot, and equals 1<<`gnt_id` whenever `gnt_valid`=1.

## Test plan
- Reset behaviour: hold `rst_n`=0 with `req`=8'hFF → all outputs 0. Release reset → `gnt`=8'h80 and `gnt_id`=7 one cycle later.
- Fixed priority: `mode`=0, `req`=8'b0010_0110, pulse `done` after each grant. Grants are 5, 5, 5 (same winner each time); `gnt_valid` is low for exactly one cycle between grants.
- Round-robin: `mode`=1, `req`=8'hFF, pulse `done` after every grant. Grant sequence is 7,6,5,4,3,2,1,0,7 (wrap). Then `req`=8'b1000_0001 from `ptr`=6 → grants 0, then 7.
- Timeout: `TIMEOUT`=4, `req[3]` held, `done`=0. `gnt`=8'h08 for 4 cycles, then `timeout` pulses once, then a regrant to 3 after one IDLE cycle. Repeat with `TIMEOUT`=0 → grant held for 300 cycles with no pulse.
- Withdrawal and enable: owner 2 drops `req[2]` → grant clears next cycle with no `timeout` pulse. With `ena`=0 during GRANT → grant clears; `req`=8'hFF while `ena`=0 → no grant ever.
- Async reset mid-grant: assert `rst_n`=0 between clock edges while `gnt`=8'h10 → `gnt`=0 immediately. After release, `ptr` is back to 7 (next round-robin grant with `req`=8'hFF is 7).
